alu: RTL and testbench
======================

// Module: alu
//
// PURPOSE
// - 8-bit registered ALU for the single-cycle-issue datapath; one op per clock.
// - Takes two register operands rs_i and rt_i and a 3-bit opcode.
// - Produces an 8-bit result plus zero and set flags, all registered.
// - Flags feed branch and compare logic in the control unit.
//
// PARAMETERS
// - WIDTH  8  operand/result width; all rules below are written for WIDTH=8.
//
// PORTS
// - clk           in   1      clock; rising edge
// - rst           in   1      reset; asynchronous, active-high
// - valid_i       in   1      operands/opcode valid this cycle
// - rs_i          in   WIDTH  operand A
// - rt_i          in   WIDTH  operand B; ignored by unary ops
// - opcode_i      in   3      operation select
// - alu_result_o  out  WIDTH  registered result
// - zero          out  1      registered: result == 0
// - set_o         out  1      registered: signed(rs_i) < signed(rt_i)
// - valid_o       out  1      registered copy of valid_i
//
// BEHAVIOUR
// - Reset (async assert, sync release): alu_result_o=0, zero=0, set_o=0, valid_o=0.
// - Latency: 1 clock.
// - When valid_i=1 at a rising edge, outputs reflect that cycle's inputs from that edge on.
// - When valid_i=0, result/zero/set_o hold their values; valid_o drops to 0.
// - No backpressure: a new op can be accepted every cycle.
// - Opcode map (modulo 2^8, no exceptions):
//   - 000 AND   rs & rt
//   - 001 OR    rs | rt
//   - 010 ADD   rs + rt; carry-out discarded
//   - 011 NOT   ~rs (rt ignored)
//   - 100 SUB   rs - rt; borrow discarded
//   - 101 CMP   rs - rt; used for BEQ via zero
//   - 110 SRL   rs >> 1 logical, MSB filled with 0 (rt ignored)
//   - 111 SLT   {7'b0, signed(rs) < signed(rt)}
// - zero is computed from the new result for every opcode.
// - set_o is computed for every opcode, not only SLT.
// - Overflow and wrap are silent in the base configuration.
// - Reset asserted mid-stream clears all outputs immediately; the in-flight op is lost.
//
// CONFIGURATION
// - ALU_FLAGS_EN defined:
//   - Adds registered outputs carry_o and ovf_o; both reset to 0.
//   - ADD: carry_o = carry-out; ovf_o = signed overflow.
//   - SUB/CMP: carry_o = borrow (rs < rt unsigned); ovf_o = signed overflow.
//   - All other ops: carry_o = 0, ovf_o = 0.
//   - Both flags update and hold under the same valid_i rules as the other outputs.
// - ALU_FLAGS_EN undefined: carry_o and ovf_o ports do not exist; behaviour otherwise identical.
//
// TESTING
// - AND 0x55, 0xAA -> result 0x00, zero=1 one cycle later.
// - OR 0x0F, 0xF0 -> 0xFF, zero=0.
// - ADD 5, 2 -> 7.
// - ADD 0xFF, 0x01 -> 0x00, zero=1 (carry_o=1 with ALU_FLAGS_EN).
// - NOT rs=0xFE -> 0x01.
// - SUB 0xFD, 0xFA -> 0x03.
// - CMP 1, 1 -> zero=1.
// - SRL 0xFF -> 0x7F.
// - SLT 0xFF, 0xFF -> result 0, zero=1, set_o=0.
// - SLT 0xFF, 0x01 -> result 1, set_o=1.
// - Back-to-back ops each cycle with valid_i=1 -> one result per cycle.
// - Drop valid_i -> outputs hold, valid_o=0.
// - Assert rst mid-stream, asynchronous to clk -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu.sv
// 8-bit registered ALU: AND/OR/ADD/NOT/SUB/CMP/SRL/SLT with zero and signed-less-than flags.
// Latency 1 clock; result/zero/set_o (and carry_o/ovf_o when ALU_FLAGS_EN is defined) hold while valid_i=0.
// No backpressure: a new op is accepted every cycle; valid_o is a registered copy of valid_i.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic [2:0]       opcode_i,
  output logic [WIDTH-1:0] alu_result_o,
  output logic             zero,
  output logic             set_o,
`ifdef ALU_FLAGS_EN
  output logic             carry_o,
  output logic             ovf_o,
`endif
  output logic             valid_o
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] result_nxt;
  logic             slt_nxt;

  // Signed compare is shared by SLT's result and the set_o flag for every opcode.
  assign slt_nxt = $signed(rs_i) < $signed(rt_i);

  // Result mux; arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    result_nxt = '0;
    unique case (opcode_i)
      OP_AND:         result_nxt = rs_i & rt_i;
      OP_OR:          result_nxt = rs_i | rt_i;
      OP_ADD:         result_nxt = rs_i + rt_i;
      OP_NOT:         result_nxt = ~rs_i;
      OP_SUB, OP_CMP: result_nxt = rs_i - rt_i;
      OP_SRL:         result_nxt = rs_i >> 1;
      OP_SLT:         result_nxt = {{(WIDTH-1){1'b0}}, slt_nxt};
      default:        result_nxt = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           carry_nxt;
  logic           ovf_nxt;

  assign sum_ext  = {1'b0, rs_i} + {1'b0, rt_i};
  assign diff_ext = {1'b0, rs_i} - {1'b0, rt_i};

  // Carry/borrow and signed overflow only for the add and subtract family; zero elsewhere.
  always_comb begin
    carry_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    unique case (opcode_i)
      OP_ADD: begin
        carry_nxt = sum_ext[WIDTH];
        ovf_nxt   = (rs_i[WIDTH-1] == rt_i[WIDTH-1]) && (sum_ext[WIDTH-1] != rs_i[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        carry_nxt = diff_ext[WIDTH];
        ovf_nxt   = (rs_i[WIDTH-1] != rt_i[WIDTH-1]) && (diff_ext[WIDTH-1] != rs_i[WIDTH-1]);
      end
      default: begin
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  // Extra flags follow the same capture/hold rule as the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else if (valid_i) begin
      carry_o <= carry_nxt;
      ovf_o   <= ovf_nxt;
    end
  end
`endif

  // Capture result and flags on valid ops; valid_o tracks valid_i every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_o <= '0;
      zero         <= 1'b0;
      set_o        <= 1'b0;
      valid_o      <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        alu_result_o <= result_nxt;
        zero         <= (result_nxt == '0);
        set_o        <= slt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed cases followed by randomized ops against an arithmetic reference model.
module tb_alu;

  logic       clk;
  logic       rst;
  logic       valid_i;
  logic [7:0] rs_i;
  logic [7:0] rt_i;
  logic [2:0] opcode_i;
  logic [7:0] alu_result_o;
  logic       zero;
  logic       set_o;
  logic       valid_o;
`ifdef ALU_FLAGS_EN
  logic       carry_o;
  logic       ovf_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the registered outputs should currently show.
  int exp_res, exp_zero, exp_set, exp_valid, exp_carry, exp_ovf;

  alu #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .rs_i         (rs_i),
    .rt_i         (rt_i),
    .opcode_i     (opcode_i),
    .alu_result_o (alu_result_o),
    .zero         (zero),
    .set_o        (set_o),
`ifdef ALU_FLAGS_EN
    .carry_o      (carry_o),
    .ovf_o        (ovf_o),
`endif
    .valid_o      (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_signed8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Behavioural model using plain integer arithmetic.
  task automatic model(input int op, input int a, input int b,
                       output int r, output int s, output int c, output int o);
    int sa, sb;
    sa = to_signed8(a);
    sb = to_signed8(b);
    r = 0; c = 0; o = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: begin
        r = (a + b) % 256;
        c = (a + b > 255) ? 1 : 0;
        o = ((sa + sb > 127) || (sa + sb < -128)) ? 1 : 0;
      end
      3: r = 255 - a;
      4, 5: begin
        r = (a - b + 256) % 256;
        c = (a < b) ? 1 : 0;
        o = ((sa - sb > 127) || (sa - sb < -128)) ? 1 : 0;
      end
      6: r = a / 2;
      default: r = (sa < sb) ? 1 : 0;
    endcase
    s = (sa < sb) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".result"}, {24'd0, alu_result_o}, exp_res);
    chk({tag, ".zero"},   {31'd0, zero},         exp_zero);
    chk({tag, ".set"},    {31'd0, set_o},        exp_set);
    chk({tag, ".valid"},  {31'd0, valid_o},      exp_valid);
`ifdef ALU_FLAGS_EN
    chk({tag, ".carry"},  {31'd0, carry_o},      exp_carry);
    chk({tag, ".ovf"},    {31'd0, ovf_o},        exp_ovf);
`endif
  endtask

  task automatic model_reset();
    exp_res = 0; exp_zero = 0; exp_set = 0; exp_valid = 0; exp_carry = 0; exp_ovf = 0;
  endtask

  // Drive one op at the falling edge, sample 1 time unit after the next rising edge.
  task automatic do_op(input string tag, input int op, input int a, input int b, input bit v);
    int r, s, c, o;
    @(negedge clk);
    valid_i  = v;
    opcode_i = op[2:0];
    rs_i     = a[7:0];
    rt_i     = b[7:0];
    @(posedge clk);
    #1;
    exp_valid = v ? 1 : 0;
    if (v) begin
      model(op, a, b, r, s, c, o);
      exp_res = r; exp_zero = (r == 0) ? 1 : 0; exp_set = s; exp_carry = c; exp_ovf = o;
    end
    check_outputs(tag);
  endtask

  // Assert reset between clock edges and confirm outputs clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b0; rs_i = '0; rt_i = '0; opcode_i = '0;
    model_reset();
    #2 rst = 1'b1;
    #1 check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    do_op("and_55_aa",  0, 8'h55, 8'hAA, 1);
    chk("and_55_aa.lit_zero", {31'd0, zero}, 1);
    do_op("or_0f_f0",   1, 8'h0F, 8'hF0, 1);
    chk("or_0f_f0.lit_res", {24'd0, alu_result_o}, 32'hFF);
    do_op("add_5_2",    2, 5, 2, 1);
    chk("add_5_2.lit_res", {24'd0, alu_result_o}, 7);
    do_op("add_ff_01",  2, 8'hFF, 8'h01, 1);
    chk("add_ff_01.lit_zero", {31'd0, zero}, 1);
    do_op("not_fe",     3, 8'hFE, 8'h33, 1);
    chk("not_fe.lit_res", {24'd0, alu_result_o}, 1);
    do_op("sub_fd_fa",  4, 8'hFD, 8'hFA, 1);
    chk("sub_fd_fa.lit_res", {24'd0, alu_result_o}, 3);
    do_op("cmp_1_1",    5, 1, 1, 1);
    do_op("srl_ff",     6, 8'hFF, 8'h12, 1);
    chk("srl_ff.lit_res", {24'd0, alu_result_o}, 32'h7F);
    do_op("slt_ff_ff",  7, 8'hFF, 8'hFF, 1);
    do_op("slt_ff_01",  7, 8'hFF, 8'h01, 1);
    chk("slt_ff_01.lit_set", {31'd0, set_o}, 1);
    do_op("add_7f_01",  2, 8'h7F, 8'h01, 1);
    do_op("sub_80_01",  4, 8'h80, 8'h01, 1);
    do_op("sub_01_02",  4, 8'h01, 8'h02, 1);

    // Valid dropped: outputs hold, valid_o falls.
    do_op("hold_0",     2, 8'h10, 8'h20, 0);
    do_op("hold_1",     0, 8'h00, 8'h00, 0);
    do_op("resume",     1, 8'h80, 8'h00, 1);

    async_reset("rst_mid_a");
    do_op("after_rst",  2, 8'h03, 8'h04, 1);

    // Randomized back-to-back traffic with occasional bubbles and one mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      do_op("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0));
      if (i == 150) async_reset("rst_mid_b");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
